// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
//   Shared encodings for the ID/EX stage of the 5-stage MIPS pipe:
//   forwarding-select codes, ALUOp codes and the packed control bundle that
//   travels with an instruction from ID into EX.
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

   // Operand source selects produced by the forwarding unit
   localparam logic [1:0] FWD_REG   = 2'b00;  // registered register-file value
   localparam logic [1:0] FWD_MEMWB = 2'b01;  // MEM/WB write-back value
   localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM ALU result

   // ALUOp encodings handed to ALU_CNTRL
   localparam logic [1:0] ALUOP_MEM = 2'b00;  // lw / sw address add
   localparam logic [1:0] ALUOP_BEQ = 2'b01;  // beq subtract
   localparam logic [1:0] ALUOP_R   = 2'b10;  // R-type, decode func

   // Control bits that ride along with the instruction
   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic [1:0] aluop;
   } ctrl_t;

   // A bubble writes nothing and asks the ALU for a harmless add
   localparam ctrl_t CTRL_BUBBLE = '{regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
                                     memtoreg: 1'b0, aluop: ALUOP_MEM};

endpackage

// File: rtl/id_ex_stage_ex_forward_unit.sv
// -----------------------------------------------------------------------------
// ex_forward_unit
//   Purely combinational RAW-hazard resolver. For each EX source index it
//   picks EX/MEM over MEM/WB over the registered read value. Register 0 is
//   hard-wired zero in MIPS and is therefore never forwarded.
// Ports
//   ex_rs, ex_rt     in   registered source indices of the instruction in EX
//   exmem_regwrite   in   EX/MEM will write a register
//   exmem_rd         in   EX/MEM destination index
//   memwb_regwrite   in   MEM/WB will write a register
//   memwb_rd         in   MEM/WB destination index
//   fwd_a_sel        out  source select for operand A (rs)
//   fwd_b_sel        out  source select for operand B (rt)
// -----------------------------------------------------------------------------
module ex_forward_unit
   import id_ex_stage_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              exmem_regwrite,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic              memwb_regwrite,
   input  logic [REG_AW-1:0] memwb_rd,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel
);

   // Priority select for one source index; the younger EX/MEM value wins
   function automatic logic [1:0] pick_source(
      input logic [REG_AW-1:0] idx,
      input logic              em_wr,
      input logic [REG_AW-1:0] em_rd,
      input logic              mw_wr,
      input logic [REG_AW-1:0] mw_rd
   );
      logic [1:0] sel;
      if (em_wr && (em_rd != {REG_AW{1'b0}}) && (em_rd == idx)) begin
         sel = FWD_EXMEM;
      end else if (mw_wr && (mw_rd != {REG_AW{1'b0}}) && (mw_rd == idx)) begin
         sel = FWD_MEMWB;
      end else begin
         sel = FWD_REG;
      end
      return sel;
   endfunction

   // Independent selects for operand A and operand B
   always_comb begin
      fwd_a_sel = pick_source(ex_rs, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
      fwd_b_sel = pick_source(ex_rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
   end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with operand forwarding and load-use detection.
//   Feeds the ALU / ALU_CNTRL pair with operands, ALUOp, func and shamt.
// Ports
//   clk, rst_n            rising-edge clock, async active-low reset
//   stall                 hold current ID/EX contents
//   flush                 replace ID/EX contents with a bubble
//   id_*                  decoded instruction fields and control from ID
//   exmem_regwrite/rd/result, memwb_regwrite/rd/data  forwarding sources
//   ex_alu_a, ex_alu_b    forwarded ALU operands (B may be the immediate)
//   ex_store_data         forwarded rt value for stores
//   ex_aluop/func/shamt   to ALU_CNTRL / ALU
//   ex_wreg               destination index resolved at capture
//   ex_regwrite/memread/memwrite/memtoreg  registered control
//   load_use_stall        upstream must hold PC and IF/ID this cycle
// -----------------------------------------------------------------------------
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [4:0]        id_shamt,
   input  logic [5:0]        id_func,
   input  logic [1:0]        id_aluop,
   input  logic              id_alusrc,
   input  logic              id_regdst,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              id_memtoreg,
   input  logic              exmem_regwrite,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_regwrite,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_data,
   output logic [DATA_W-1:0] ex_alu_a,
   output logic [DATA_W-1:0] ex_alu_b,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [1:0]        ex_aluop,
   output logic [5:0]        ex_func,
   output logic [4:0]        ex_shamt,
   output logic [REG_AW-1:0] ex_wreg,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_memtoreg,
   output logic              load_use_stall
);

   logic [DATA_W-1:0] rs_data_r;
   logic [DATA_W-1:0] rt_data_r;
   logic [DATA_W-1:0] imm_r;
   logic [REG_AW-1:0] rs_r;
   logic [REG_AW-1:0] rt_r;
   logic [REG_AW-1:0] wreg_r;
   logic [4:0]        shamt_r;
   logic [5:0]        func_r;
   logic              alusrc_r;
   ctrl_t             ctrl_r;

   logic [1:0]        fwd_a_sel_s;
   logic [1:0]        fwd_b_sel_s;
   logic [DATA_W-1:0] fwd_a_s;
   logic [DATA_W-1:0] fwd_b_s;
   logic              load_use_s;
   ctrl_t             id_ctrl_s;

   // Forwarding operand mux; unknown selects fall back to the register value
   function automatic logic [DATA_W-1:0] fwd_mux(
      input logic [1:0]        sel,
      input logic [DATA_W-1:0] reg_val,
      input logic [DATA_W-1:0] exmem_val,
      input logic [DATA_W-1:0] memwb_val
   );
      logic [DATA_W-1:0] res;
      case (sel)
         FWD_EXMEM: res = exmem_val;
         FWD_MEMWB: res = memwb_val;
         FWD_REG:   res = reg_val;
         default:   res = reg_val;
      endcase
      return res;
   endfunction

   // Bundle the incoming ID control bits for a single struct capture
   always_comb begin
      id_ctrl_s = '{regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
                    memtoreg: id_memtoreg, aluop: id_aluop};
   end

   // A load in EX whose destination is read by the instruction in ID cannot
   // be forwarded in time; the stage bubbles while upstream holds.
   always_comb begin
      load_use_s = ctrl_r.memread && (wreg_r != {REG_AW{1'b0}}) &&
                   ((wreg_r == id_rs) || (wreg_r == id_rt));
   end

   // ID/EX register: bubble beats hold beats capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_data_r <= {DATA_W{1'b0}};
         rt_data_r <= {DATA_W{1'b0}};
         imm_r     <= {DATA_W{1'b0}};
         rs_r      <= {REG_AW{1'b0}};
         rt_r      <= {REG_AW{1'b0}};
         wreg_r    <= {REG_AW{1'b0}};
         shamt_r   <= 5'd0;
         func_r    <= 6'd0;
         alusrc_r  <= 1'b0;
         ctrl_r    <= CTRL_BUBBLE;
      end else if (flush || load_use_s) begin
         rs_data_r <= {DATA_W{1'b0}};
         rt_data_r <= {DATA_W{1'b0}};
         imm_r     <= {DATA_W{1'b0}};
         rs_r      <= {REG_AW{1'b0}};
         rt_r      <= {REG_AW{1'b0}};
         wreg_r    <= {REG_AW{1'b0}};
         shamt_r   <= 5'd0;
         func_r    <= 6'd0;
         alusrc_r  <= 1'b0;
         ctrl_r    <= CTRL_BUBBLE;
      end else if (!stall) begin
         rs_data_r <= id_rs_data;
         rt_data_r <= id_rt_data;
         imm_r     <= id_imm;
         rs_r      <= id_rs;
         rt_r      <= id_rt;
         wreg_r    <= id_regdst ? id_rd : id_rt;
         shamt_r   <= id_shamt;
         func_r    <= id_func;
         alusrc_r  <= id_alusrc;
         ctrl_r    <= id_ctrl_s;
      end
   end

   ex_forward_unit #(
      .REG_AW (REG_AW)
   ) u_fwd (
      .ex_rs          (rs_r),
      .ex_rt          (rt_r),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .fwd_a_sel      (fwd_a_sel_s),
      .fwd_b_sel      (fwd_b_sel_s)
   );

   // Forwarded operands; the store value is the forwarded rt regardless of alusrc
   always_comb begin
      fwd_a_s = fwd_mux(fwd_a_sel_s, rs_data_r, exmem_result, memwb_data);
      fwd_b_s = fwd_mux(fwd_b_sel_s, rt_data_r, exmem_result, memwb_data);
      if (alusrc_r) begin
         ex_alu_b = imm_r;
      end else begin
         ex_alu_b = fwd_b_s;
      end
      ex_alu_a      = fwd_a_s;
      ex_store_data = fwd_b_s;
   end

   // Registered fields straight to the EX consumers
   always_comb begin
      ex_aluop       = ctrl_r.aluop;
      ex_func        = func_r;
      ex_shamt       = shamt_r;
      ex_wreg        = wreg_r;
      ex_regwrite    = ctrl_r.regwrite;
      ex_memread     = ctrl_r.memread;
      ex_memwrite    = ctrl_r.memwrite;
      ex_memtoreg    = ctrl_r.memtoreg;
      load_use_stall = load_use_s;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed bench for id_ex_stage. Expected EX-side contents are queued when
//   an instruction is driven and popped/compared once the stage presents it.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [5:0]  id_func;
   logic [1:0]  id_aluop;
   logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_data;
   logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
   logic [1:0]  ex_aluop;
   logic [5:0]  ex_func;
   logic [4:0]  ex_shamt, ex_wreg;
   logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_func(id_func), .id_aluop(id_aluop), .id_alusrc(id_alusrc),
      .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_store_data(ex_store_data),
      .ex_aluop(ex_aluop), .ex_func(ex_func), .ex_shamt(ex_shamt), .ex_wreg(ex_wreg),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg), .load_use_stall(load_use_stall)
   );

   typedef struct {
      logic [31:0] a, b, st;
      logic [1:0]  aluop;
      logic [5:0]  func;
      logic [4:0]  shamt, wreg;
      logic        rw, mr, mw, mtr;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expect_ex(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                            input logic [1:0] aluop, input logic [5:0] func,
                            input logic [4:0] shamt, input logic [4:0] wreg,
                            input logic rw, input logic mr, input logic mw, input logic mtr);
      exp_t e;
      e.a = a; e.b = b; e.st = st; e.aluop = aluop; e.func = func; e.shamt = shamt;
      e.wreg = wreg; e.rw = rw; e.mr = mr; e.mw = mw; e.mtr = mtr;
      sb.push_back(e);
   endtask

   task automatic expect_bubble();
      expect_ex(32'd0, 32'd0, 32'd0, 2'b00, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_ex(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
      end else begin
         e = sb.pop_front();
         check({tag, ".alu_a"},    ex_alu_a,               e.a);
         check({tag, ".alu_b"},    ex_alu_b,               e.b);
         check({tag, ".store"},    ex_store_data,          e.st);
         check({tag, ".aluop"},    {30'd0, ex_aluop},      {30'd0, e.aluop});
         check({tag, ".func"},     {26'd0, ex_func},       {26'd0, e.func});
         check({tag, ".shamt"},    {27'd0, ex_shamt},      {27'd0, e.shamt});
         check({tag, ".wreg"},     {27'd0, ex_wreg},       {27'd0, e.wreg});
         check({tag, ".regwrite"}, {31'd0, ex_regwrite},   {31'd0, e.rw});
         check({tag, ".memread"},  {31'd0, ex_memread},    {31'd0, e.mr});
         check({tag, ".memwrite"}, {31'd0, ex_memwrite},   {31'd0, e.mw});
         check({tag, ".memtoreg"}, {31'd0, ex_memtoreg},   {31'd0, e.mtr});
      end
   endtask

   task automatic drive_id(input logic [31:0] rs_data, input logic [31:0] rt_data,
                           input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] func,
                           input logic [1:0] aluop, input logic alusrc, input logic regdst,
                           input logic rw, input logic mr, input logic mw, input logic mtr);
      id_rs_data = rs_data; id_rt_data = rt_data; id_imm = imm;
      id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = shamt; id_func = func;
      id_aluop = aluop; id_alusrc = alusrc; id_regdst = regdst;
      id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mtr;
   endtask

   task automatic set_fwd(input logic em_wr, input logic [4:0] em_rd, input logic [31:0] em_val,
                          input logic mw_wr, input logic [4:0] mw_rd, input logic [31:0] mw_val);
      exmem_regwrite = em_wr; exmem_rd = em_rd; exmem_result = em_val;
      memwb_regwrite = mw_wr; memwb_rd = mw_rd; memwb_data = mw_val;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      drive_id(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 2'b00, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0);
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Reset state
      #2;
      expect_bubble();
      check_ex("reset");
      check("reset.lus", {31'd0, load_use_stall}, 32'd0);
      #10 rst_n = 1'b1;
      tick();

      // Plain R-type: add $3,$1,$2
      drive_id(32'd5, 32'd7, 32'h10, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32, 2'b10, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
      expect_ex(32'd5, 32'd7, 32'd7, 2'b10, 6'd32, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_ex("rtype");

      // Forwarding priority on rs=1, rt=2
      drive_id(32'd11, 32'd22, 32'd0, 5'd1, 5'd2, 5'd9, 5'd4, 6'd34, 2'b10, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_fwd(1'b1, 5'd1, 32'd100, 1'b1, 5'd1, 32'd200);
      expect_ex(32'd100, 32'd22, 32'd22, 2'b10, 6'd34, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 check_ex("fwd_exmem");
      exmem_regwrite = 1'b0;
      expect_ex(32'd200, 32'd22, 32'd22, 2'b10, 6'd34, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 check_ex("fwd_memwb");
      set_fwd(1'b1, 5'd2, 32'd100, 1'b1, 5'd1, 32'd200);
      expect_ex(32'd200, 32'd100, 32'd100, 2'b10, 6'd34, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 check_ex("fwd_split");

      // Register 0 is never forwarded
      set_fwd(1'b1, 5'd0, 32'd100, 1'b1, 5'd0, 32'd200);
      drive_id(32'd11, 32'd22, 32'd0, 5'd0, 5'd0, 5'd9, 5'd4, 6'd34, 2'b10, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
      expect_ex(32'd11, 32'd22, 32'd22, 2'b10, 6'd34, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_ex("fwd_r0");
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Load-use on rs: lw $4,8($1) then add $5,$4,$2
      drive_id(32'd50, 32'd0, 32'd8, 5'd1, 5'd4, 5'd0, 5'd0, 6'd0, 2'b00, 1'b1, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b1);
      expect_ex(32'd50, 32'd8, 32'd0, 2'b00, 6'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      check_ex("lw");
      drive_id(32'd60, 32'd70, 32'd0, 5'd4, 5'd2, 5'd5, 5'd0, 6'd32, 2'b10, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
      #1 check("lus_hi", {31'd0, load_use_stall}, 32'd1);
      expect_bubble();
      tick();
      check_ex("lus_bubble");
      check("lus_lo", {31'd0, load_use_stall}, 32'd0);
      expect_ex(32'd60, 32'd70, 32'd70, 2'b10, 6'd32, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_ex("replay");

      // Load into $0 never stalls
      drive_id(32'd50, 32'd0, 32'd8, 5'd1, 5'd0, 5'd0, 5'd0, 6'd0, 2'b00, 1'b1, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b1);
      expect_ex(32'd50, 32'd8, 32'd0, 2'b00, 6'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      check_ex("lw_r0");
      drive_id(32'd33, 32'd44, 32'd0, 5'd0, 5'd0, 5'd7, 5'd0, 6'd32, 2'b10, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
      #1 check("lus_r0", {31'd0, load_use_stall}, 32'd0);
      expect_ex(32'd33, 32'd44, 32'd44, 2'b10, 6'd32, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_ex("r0_nostall");

      // Load-use on rt
      drive_id(32'd50, 32'd0, 32'd8, 5'd1, 5'd6, 5'd0, 5'd0, 6'd0, 2'b00, 1'b1, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      drive_id(32'd1, 32'd2, 32'd0, 5'd1, 5'd6, 5'd5, 5'd0, 6'd32, 2'b10, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
      #1 check("lus_rt", {31'd0, load_use_stall}, 32'd1);
      expect_bubble();
      tick();
      check_ex("lus_rt_bubble");

      // Capture Y, then flush+stall on Z gives a bubble, then Z captures
      drive_id(32'h123, 32'h456, 32'd0, 5'd3, 5'd5, 5'd8, 5'd3, 6'd36, 2'b10, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
      expect_ex(32'h123, 32'h456, 32'h456, 2'b10, 6'd36, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_ex("cap_y");
      drive_id(32'hAAAA, 32'hBBBB, 32'd0, 5'd7, 5'd8, 5'd10, 5'd0, 6'd37, 2'b10, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
      flush = 1'b1; stall = 1'b1;
      expect_bubble();
      tick();
      check_ex("flush_stall");
      flush = 1'b0; stall = 1'b0;
      expect_ex(32'hAAAA, 32'hBBBB, 32'hBBBB, 2'b10, 6'd37, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_ex("cap_z");

      // Stall alone holds Z while ID changes
      stall = 1'b1;
      drive_id(32'd1, 32'd2, 32'd0, 5'd9, 5'd10, 5'd11, 5'd1, 6'd38, 2'b10, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         expect_ex(32'hAAAA, 32'hBBBB, 32'hBBBB, 2'b10, 6'd37, 5'd0, 5'd10,
                   1'b1, 1'b0, 1'b0, 1'b0);
         tick();
         check_ex("stall_hold");
      end
      stall = 1'b0;

      // sw $6,-4($1) with rt forwarded from MEM/WB
      drive_id(32'd1000, 32'h1111, 32'hFFFF_FFFC, 5'd1, 5'd6, 5'd0, 5'd0, 6'd0, 2'b00, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0000_DEAD);
      expect_ex(32'd1000, 32'hFFFF_FFFC, 32'h0000_DEAD, 2'b00, 6'd0, 5'd0, 5'd6,
                1'b0, 1'b0, 1'b1, 1'b0);
      #1 check_ex("sw_fwd");

      // Reset asserted mid-cycle while stalled
      stall = 1'b1;
      tick();
      #3 rst_n = 1'b0;
      expect_bubble();
      #1 check_ex("rst_mid");
      check("rst_mid.lus", {31'd0, load_use_stall}, 32'd0);
      check("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
